// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: byte width and the one-hot
// state encoding used by the UART blocks.
package uart_pkg;

  localparam int UART_DW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b01,
    SEND = 2'b10
  } tx_state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Circular byte buffer with occupancy count, full/empty flags and a registered
// overflow pulse for writes dropped while full.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [UART_DW-1:0] wr_data,
  input  logic               pop,
  output logic [UART_DW-1:0] rd_data,
  output logic               full,
  output logic               empty,
  output logic [ADDR_W:0]    count,
  output logic               overflow
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  logic [UART_DW-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]  rd_ptr;
  logic [ADDR_W-1:0]  wr_ptr;
  logic               push;

  // full is judged on the registered count, so a pop in the same cycle
  // does not make room for a write.
  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign push    = wr_en && !full;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= wr_en && full;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffers host bytes and hands them one at a time to the UART transmitter,
// advancing only on a fresh rising edge of donetx.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [UART_DW-1:0] wr_data,
  output logic               full,
  output logic               empty,
  output logic [ADDR_W:0]    count,
  output logic               overflow,
  output logic               busy,
  output logic               newd,
  output logic [UART_DW-1:0] dintx,
  input  logic               donetx
);

  tx_state_t          state;
  logic               donetx_q;
  logic               done_rise;
  logic               pop;
  logic [UART_DW-1:0] rd_data;

  // A donetx level left over from the previous frame is not a rise, so the
  // byte just presented is never completed early.
  assign done_rise = donetx && !donetx_q;
  assign pop       = (state == SEND) && done_rise;
  assign busy      = (state == SEND);

  uart_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .pop      (pop),
    .rd_data  (rd_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      newd     <= 1'b0;
      dintx    <= '0;
      donetx_q <= 1'b0;
    end else begin
      donetx_q <= donetx;
      case (state)
        IDLE: begin
          if (!empty) begin
            dintx <= rd_data;
            newd  <= 1'b1;
            state <= SEND;
          end else begin
            newd <= 1'b0;
          end
        end
        SEND: begin
          if (done_rise) begin
            newd  <= 1'b0;
            state <= IDLE;
          end else begin
            newd <= 1'b1;
          end
        end
        default: begin
          newd  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a vector table for the basic flow plus
// hand sequences for wrap, full/overflow and reset during a send.
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       busy;
  logic       newd;
  logic [7:0] dintx;
  logic       donetx;

  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];

  uart_tx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .busy     (busy),
    .newd     (newd),
    .dintx    (dintx),
    .donetx   (donetx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       donetx;
    logic       exp_newd;
    logic [7:0] exp_dintx;
    logic [4:0] exp_count;
  } vec_t;

  vec_t vecs[29];

  function automatic vec_t mk(string name, logic r, logic w, logic [7:0] d,
                              logic dn, logic en, logic [7:0] ed, logic [4:0] ec);
    vec_t v;
    v.name = name; v.rst = r; v.wr_en = w; v.wr_data = d; v.donetx = dn;
    v.exp_newd = en; v.exp_dintx = ed; v.exp_count = ec;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(vec_t v);
    rst = v.rst; wr_en = v.wr_en; wr_data = v.wr_data; donetx = v.donetx;
    tick();
    check_output({v.name, ".newd"}, 8'(newd), 8'(v.exp_newd));
    check_output({v.name, ".busy"}, 8'(busy), 8'(v.exp_newd));
    check_output({v.name, ".dintx"}, dintx, v.exp_dintx);
    check_output({v.name, ".count"}, 8'(count), 8'(v.exp_count));
    check_output({v.name, ".empty"}, 8'(empty), 8'(v.exp_count == 5'd0));
    check_output({v.name, ".full"}, 8'(full), 8'(v.exp_count == 5'd16));
    check_output({v.name, ".overflow"}, 8'(overflow), 8'h00);
  endtask

  task automatic write_byte(logic [7:0] d);
    logic was_full;
    was_full = (q.size() == 16);
    wr_en = 1'b1; wr_data = d;
    tick();
    wr_en = 1'b0;
    if (!was_full) q.push_back(d);
    check_output("wr.count", 8'(count), 8'(q.size()));
    check_output("wr.overflow", 8'(overflow), 8'(was_full));
  endtask

  task automatic wait_newd(string name);
    int n = 0;
    while (newd !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check_output({name, ".newd_timeout"}, 8'(newd), 8'h01);
    check_output({name, ".dintx"}, dintx, q[0]);
  endtask

  // Completes the in-flight byte, optionally writing in the same cycle.
  task automatic pop_byte(logic with_wr, logic [7:0] d);
    logic was_full;
    was_full = (q.size() == 16);
    donetx = 1'b1; wr_en = with_wr; wr_data = d;
    tick();
    void'(q.pop_front());
    if (with_wr && !was_full) q.push_back(d);
    check_output("pop.newd", 8'(newd), 8'h00);
    check_output("pop.count", 8'(count), 8'(q.size()));
    check_output("pop.overflow", 8'(overflow), 8'(with_wr && was_full));
    donetx = 1'b0; wr_en = 1'b0;
    tick();
    if (q.size() > 0) begin
      check_output("next.newd", 8'(newd), 8'h01);
      check_output("next.dintx", dintx, q[0]);
    end else begin
      check_output("next.newd", 8'(newd), 8'h00);
      check_output("next.empty", 8'(empty), 8'h01);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_data = 8'h00; donetx = 1'b0;

    vecs[0]  = mk("reset",       1, 0, 8'h00, 0, 0, 8'h00, 0);
    vecs[1]  = mk("idle",        0, 0, 8'h00, 0, 0, 8'h00, 0);
    vecs[2]  = mk("wr_a5",       0, 1, 8'hA5, 0, 0, 8'h00, 1);
    vecs[3]  = mk("present_a5",  0, 0, 8'h00, 0, 1, 8'hA5, 1);
    vecs[4]  = mk("done_a5",     0, 0, 8'h00, 1, 0, 8'hA5, 0);
    vecs[5]  = mk("done_hold",   0, 0, 8'h00, 1, 0, 8'hA5, 0);
    vecs[6]  = mk("done_low",    0, 0, 8'h00, 0, 0, 8'hA5, 0);
    vecs[7]  = mk("wr_01",       0, 1, 8'h01, 0, 0, 8'hA5, 1);
    vecs[8]  = mk("wr_02",       0, 1, 8'h02, 0, 1, 8'h01, 2);
    vecs[9]  = mk("wr_03",       0, 1, 8'h03, 0, 1, 8'h01, 3);
    vecs[10] = mk("done_01",     0, 0, 8'h00, 1, 0, 8'h01, 2);
    vecs[11] = mk("present_02",  0, 0, 8'h00, 1, 1, 8'h02, 2);
    vecs[12] = mk("stale_done",  0, 0, 8'h00, 1, 1, 8'h02, 2);
    vecs[13] = mk("done_fall",   0, 0, 8'h00, 0, 1, 8'h02, 2);
    vecs[14] = mk("done_02",     0, 0, 8'h00, 1, 0, 8'h02, 1);
    vecs[15] = mk("present_03",  0, 0, 8'h00, 0, 1, 8'h03, 1);
    vecs[16] = mk("done_03",     0, 0, 8'h00, 1, 0, 8'h03, 0);
    vecs[17] = mk("drained",     0, 0, 8'h00, 0, 0, 8'h03, 0);
    vecs[18] = mk("wr_10",       0, 1, 8'h10, 0, 0, 8'h03, 1);
    vecs[19] = mk("wr_11",       0, 1, 8'h11, 0, 1, 8'h10, 2);
    vecs[20] = mk("wr_12",       0, 1, 8'h12, 0, 1, 8'h10, 3);
    vecs[21] = mk("wr_and_pop",  0, 1, 8'h13, 1, 0, 8'h10, 3);
    vecs[22] = mk("present_11",  0, 0, 8'h00, 0, 1, 8'h11, 3);
    vecs[23] = mk("done_11",     0, 0, 8'h00, 1, 0, 8'h11, 2);
    vecs[24] = mk("present_12",  0, 0, 8'h00, 0, 1, 8'h12, 2);
    vecs[25] = mk("done_12",     0, 0, 8'h00, 1, 0, 8'h12, 1);
    vecs[26] = mk("present_13",  0, 0, 8'h00, 0, 1, 8'h13, 1);
    vecs[27] = mk("done_13",     0, 0, 8'h00, 1, 0, 8'h13, 0);
    vecs[28] = mk("idle_again",  0, 0, 8'h00, 0, 0, 8'h13, 0);

    for (int i = 0; i < 29; i++) apply_stimulus(vecs[i]);
    rst = 1'b0; wr_en = 1'b0; donetx = 1'b0;
    q.delete();

    // Pointers sit at 8; keep three entries while writing and popping together
    // so both pointers run through the 15 -> 0 wrap.
    write_byte(8'h40);
    write_byte(8'h41);
    write_byte(8'h42);
    wait_newd("wrap");
    for (int i = 0; i < 10; i++) pop_byte(1'b1, 8'h43 + 8'(i));
    while (q.size() > 0) pop_byte(1'b0, 8'h00);

    // Fill to the brim with no completions, then overflow twice: once idle,
    // once while a pop happens in the same cycle.
    for (int i = 0; i < 16; i++) write_byte(8'h80 + 8'(i));
    check_output("full.flag", 8'(full), 8'h01);
    write_byte(8'hEE);
    check_output("full.count", 8'(count), 8'd16);
    tick();
    check_output("overflow.one_cycle", 8'(overflow), 8'h00);
    wait_newd("full");
    pop_byte(1'b1, 8'hEF);
    while (q.size() > 0) pop_byte(1'b0, 8'h00);

    // Reset while a byte is being sent abandons it and everything queued.
    for (int i = 0; i < 4; i++) write_byte(8'h90 + 8'(i));
    wait_newd("midsend");
    check_output("midsend.busy", 8'(busy), 8'h01);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q.delete();
    check_output("rst.count", 8'(count), 8'h00);
    check_output("rst.newd", 8'(newd), 8'h00);
    check_output("rst.busy", 8'(busy), 8'h00);
    check_output("rst.empty", 8'(empty), 8'h01);
    for (int i = 0; i < 8; i++) begin
      tick();
      check_output("rst.quiet_newd", 8'(newd), 8'h00);
    end
    write_byte(8'h77);
    wait_newd("after_rst");
    pop_byte(1'b0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
